// File: rtl/deconv_pkg.sv
// Shared constants, types and IEEE-754 binary64 classification helpers
// for the deconvolution block and its arithmetic unit.
package deconv_pkg;

    localparam int DATA_W  = 64;
    localparam int MAX_LEN = 256;
    localparam int IDX_W   = $clog2(MAX_LEN);

    typedef logic [63:0] fp64_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        INIT = 3'd2,
        MAC  = 3'd3,
        DIV  = 3'd4,
        FIN  = 3'd5
    } state_t;

    localparam fp64_t FP_ZERO = 64'h0;
    localparam fp64_t FP_QNAN = 64'h7FF8_0000_0000_0000;

    function automatic logic fp_is_nan(input fp64_t x);
        return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
    endfunction

    function automatic logic fp_is_inf(input fp64_t x);
        return (x[62:52] == 11'h7FF) && (x[51:0] == 52'd0);
    endfunction

    function automatic logic fp_is_zero(input fp64_t x);
        return (x[62:0] == 63'd0);
    endfunction

endpackage

// File: rtl/fp64_msub_div.sv
// Combinational binary64 unit: o_res = i_acc - i_a*i_b (i_mode=0)
// or o_res = i_acc / i_b (i_mode=1). Round-to-nearest-even, full subnormal support.
module fp64_msub_div
    import deconv_pkg::*;
(
    input  logic  i_mode,
    input  fp64_t i_acc,
    input  fp64_t i_a,
    input  fp64_t i_b,
    output fp64_t o_res
);

    // m holds the significand with its leading one at bit 63 (sticky jammed into bit 0),
    // e is the biased exponent of that leading one; denormalises and rounds RNE.
    function automatic fp64_t round_pack(input logic s, input logic signed [13:0] e,
                                         input logic [63:0] m);
        logic [63:0]        mm;
        logic signed [13:0] ee;
        logic [53:0]        r;
        logic               rnd;
        int                 sh;
        mm = m;
        ee = e;
        if (ee < 14'sd1) begin
            sh = 1 - int'(ee);
            if (sh > 63) mm = {63'd0, |m};
            else         mm = (m >> sh) | {63'd0, |(m & ((64'd1 << sh) - 64'd1))};
            ee = 14'sd0;
        end
        rnd = mm[10] & ((|mm[9:0]) | mm[11]);
        r   = {1'b0, mm[63:11]} + {53'd0, rnd};
        if (r[53]) begin
            r  = r >> 1;
            ee = ee + 14'sd1;
        end
        if ((ee == 14'sd0) && r[52]) ee = 14'sd1;
        if (ee >= 14'sd2047) return {s, 11'h7FF, 52'd0};
        return {s, ee[10:0], r[51:0]};
    endfunction

    // Unpack to a 53-bit significand with leading one at bit 52 (subnormals normalised).
    function automatic void unpack_norm(input fp64_t x, output logic [52:0] m,
                                        output logic signed [13:0] e);
        m = {|x[62:52], x[51:0]};
        e = (x[62:52] == 11'd0) ? 14'sd1 : $signed({3'b000, x[62:52]});
        for (int i = 0; i < 52; i++) begin
            if (!m[52]) begin
                m = m << 1;
                e = e - 14'sd1;
            end
        end
    endfunction

    function automatic fp64_t fp_mul(input fp64_t a, input fp64_t b);
        logic               s;
        logic [52:0]        ma, mb;
        logic signed [13:0] ea, eb, e;
        logic [105:0]       p;
        logic [63:0]        m;
        s = a[63] ^ b[63];
        if (fp_is_nan(a) || fp_is_nan(b)) return FP_QNAN;
        if ((fp_is_inf(a) && fp_is_zero(b)) || (fp_is_zero(a) && fp_is_inf(b))) return FP_QNAN;
        if (fp_is_inf(a) || fp_is_inf(b)) return {s, 11'h7FF, 52'd0};
        if (fp_is_zero(a) || fp_is_zero(b)) return {s, 63'd0};
        unpack_norm(a, ma, ea);
        unpack_norm(b, mb, eb);
        p = {53'd0, ma} * {53'd0, mb};
        if (p[105]) begin
            m = {p[105:43], |p[42:0]};
            e = ea + eb - 14'sd1022;
        end else begin
            m = {p[104:42], |p[41:0]};
            e = ea + eb - 14'sd1023;
        end
        return round_pack(s, e, m);
    endfunction

    function automatic fp64_t fp_add(input fp64_t a, input fp64_t b);
        fp64_t              x, y;
        logic signed [13:0] ex, ey, e;
        logic [63:0]        wx, wy, w;
        int                 d;
        if (fp_is_nan(a) || fp_is_nan(b)) return FP_QNAN;
        if (fp_is_inf(a) && fp_is_inf(b) && (a[63] != b[63])) return FP_QNAN;
        if (fp_is_inf(a)) return a;
        if (fp_is_inf(b)) return b;
        if (fp_is_zero(a) && fp_is_zero(b)) return {a[63] & b[63], 63'd0};
        if (fp_is_zero(a)) return b;
        if (fp_is_zero(b)) return a;
        // x is the operand of larger magnitude; its sign is the result sign
        if (a[62:0] < b[62:0]) begin
            x = b;
            y = a;
        end else begin
            x = a;
            y = b;
        end
        ex = (x[62:52] == 11'd0) ? 14'sd1 : $signed({3'b000, x[62:52]});
        ey = (y[62:52] == 11'd0) ? 14'sd1 : $signed({3'b000, y[62:52]});
        wx = {1'b0, |x[62:52], x[51:0], 10'd0};
        wy = {1'b0, |y[62:52], y[51:0], 10'd0};
        d  = int'(ex) - int'(ey);
        if (d > 63)     wy = 64'd1;
        else if (d > 0) wy = (wy >> d) | {63'd0, |(wy & ((64'd1 << d) - 64'd1))};
        if (x[63] == y[63]) w = wx + wy;
        else                w = wx - wy;
        if (w == 64'd0) return FP_ZERO;
        e = ex + 14'sd1;
        for (int i = 0; i < 63; i++) begin
            if (!w[63]) begin
                w = w << 1;
                e = e - 14'sd1;
            end
        end
        return round_pack(x[63], e, w);
    endfunction

    function automatic fp64_t fp_div(input fp64_t a, input fp64_t b);
        logic               s, stk;
        logic [52:0]        ma, mb;
        logic signed [13:0] ea, eb, e;
        logic [53:0]        rem;
        logic [63:0]        q, m;
        s = a[63] ^ b[63];
        if (fp_is_nan(a) || fp_is_nan(b)) return FP_QNAN;
        if ((fp_is_zero(a) && fp_is_zero(b)) || (fp_is_inf(a) && fp_is_inf(b))) return FP_QNAN;
        if (fp_is_inf(a) || fp_is_zero(b)) return {s, 11'h7FF, 52'd0};
        if (fp_is_inf(b) || fp_is_zero(a)) return {s, 63'd0};
        unpack_norm(a, ma, ea);
        unpack_norm(b, mb, eb);
        rem = {1'b0, ma};
        q   = 64'd0;
        // restoring division: q = floor(ma/mb * 2^63)
        for (int i = 63; i >= 0; i--) begin
            if (rem >= {1'b0, mb}) begin
                q[i] = 1'b1;
                rem  = rem - {1'b0, mb};
            end
            rem = rem << 1;
        end
        stk = |rem;
        if (q[63]) begin
            m = q | {63'd0, stk};
            e = ea - eb + 14'sd1023;
        end else begin
            m = {q[62:0], stk};
            e = ea - eb + 14'sd1022;
        end
        return round_pack(s, e, m);
    endfunction

    // Select between multiply-subtract and divide
    always_comb begin
        o_res = FP_ZERO;
        if (i_mode) o_res = fp_div(i_acc, i_b);
        else        o_res = fp_add(i_acc, fp_mul({~i_a[63], i_a[62:0]}, i_b));
    end

endmodule

// File: rtl/deconvolution.sv
// Deconvolution engine: recovers x from y = x (*) h by solving the causal
// recurrence x[n] = (y[n] - sum h[k]*x[n-k]) / h[0], one MAC tap per cycle.
// Optional build macro DECONV_ZERO_CHECK_EN rejects a zero h[0] up front.
module deconvolution
    import deconv_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [IDX_W-1:0]          len_y,
    input  logic [IDX_W-1:0]          len_k,
    input  logic [MAX_LEN*DATA_W-1:0] y_in,
    input  logic [MAX_LEN*DATA_W-1:0] h_in,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [IDX_W-1:0]          len_x,
    output logic [MAX_LEN*DATA_W-1:0] x_out
);

    state_t           r_state;
    fp64_t            r_y [MAX_LEN];
    fp64_t            r_h [MAX_LEN];
    fp64_t            r_x [MAX_LEN];
    fp64_t            r_acc;
    logic [IDX_W-1:0] r_ly, r_lk, r_lx, r_n, r_k, r_kmax;
    logic             r_busy, r_done, r_err;

    logic             w_len_bad, w_h0_zero, w_mode;
    logic [IDX_W-1:0] w_kmax, w_xidx;
    fp64_t            w_opa, w_opb, w_res;

    assign w_len_bad = (r_lk == '0) || (r_lk > r_ly);
`ifdef DECONV_ZERO_CHECK_EN
    assign w_h0_zero = (r_h[0][62:52] == 11'd0) && (r_h[0][51:0] == 52'd0);
`else
    assign w_h0_zero = 1'b0;
`endif
    assign w_kmax = (r_n < (r_lk - 8'd1)) ? r_n : (r_lk - 8'd1);
    assign w_xidx = r_n - r_k;
    assign w_mode = (r_state == DIV);
    assign w_opa  = r_h[r_k];
    assign w_opb  = w_mode ? r_h[0] : r_x[w_xidx];

    fp64_msub_div u_fpu (
        .i_mode (w_mode),
        .i_acc  (r_acc),
        .i_a    (w_opa),
        .i_b    (w_opb),
        .o_res  (w_res)
    );

    // Control FSM: sequencing, lengths, status flags
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_lx    <= '0;
            r_ly    <= '0;
            r_lk    <= '0;
            r_n     <= '0;
            r_k     <= '0;
            r_kmax  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= LOAD;
                        r_busy  <= 1'b1;
                        r_err   <= 1'b0;
                        r_lx    <= '0;
                        r_ly    <= len_y;
                        r_lk    <= len_k;
                    end
                end
                LOAD: begin
                    if (w_len_bad || w_h0_zero) begin
                        r_err   <= 1'b1;
                        r_lx    <= '0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= FIN;
                    end else begin
                        r_lx    <= r_ly - r_lk + 8'd1;
                        r_n     <= '0;
                        r_state <= INIT;
                    end
                end
                INIT: begin
                    r_k     <= 8'd1;
                    r_kmax  <= w_kmax;
                    r_state <= (w_kmax == '0) ? DIV : MAC;
                end
                MAC: begin
                    r_k <= r_k + 8'd1;
                    if (r_k == r_kmax) r_state <= DIV;
                end
                DIV: begin
                    if (r_n == (r_lx - 8'd1)) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= FIN;
                    end else begin
                        r_n     <= r_n + 8'd1;
                        r_state <= INIT;
                    end
                end
                FIN:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Operand capture at start and accumulator update
    always_ff @(posedge clk) begin
        if ((r_state == IDLE) && start) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_y[i] <= y_in[i*DATA_W +: DATA_W];
                r_h[i] <= h_in[i*DATA_W +: DATA_W];
            end
        end
        if (r_state == INIT)     r_acc <= r_y[r_n];
        else if (r_state == MAC) r_acc <= w_res;
    end

    // Result array: cleared on reset and at LOAD, one sample written per DIV
    always_ff @(posedge clk) begin
        if (!reset || (r_state == LOAD)) begin
            for (int i = 0; i < MAX_LEN; i++) r_x[i] <= FP_ZERO;
        end else if (r_state == DIV) begin
            r_x[r_n] <= w_res;
        end
    end

    for (genvar g = 0; g < MAX_LEN; g++) begin : g_xout
        assign x_out[g*DATA_W +: DATA_W] = r_x[g];
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign err   = r_err;
    assign len_x = r_lx;

endmodule

// File: tb/tb_deconvolution.sv
// Directed bench for deconvolution: hand-computed binary64 vectors and latencies.
module tb_deconvolution;

    localparam logic [63:0] F1   = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] F2   = 64'h4000_0000_0000_0000;
    localparam logic [63:0] F3   = 64'h4008_0000_0000_0000;
    localparam logic [63:0] F4   = 64'h4010_0000_0000_0000;
    localparam logic [63:0] F5   = 64'h4014_0000_0000_0000;
    localparam logic [63:0] F6   = 64'h4018_0000_0000_0000;
    localparam logic [63:0] F8   = 64'h4020_0000_0000_0000;
    localparam logic [63:0] FH   = 64'h3FE0_0000_0000_0000;
    localparam logic [63:0] FMH  = 64'hBFE0_0000_0000_0000;
    localparam logic [63:0] FNZ  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] FNI  = 64'hFFF0_0000_0000_0000;
    localparam logic [63:0] F13  = 64'h3FD5_5555_5555_5555;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [7:0]      len_y = 8'd0;
    logic [7:0]      len_k = 8'd0;
    logic [16383:0]  y_in = '0;
    logic [16383:0]  h_in = '0;
    logic            busy, done, err;
    logic [7:0]      len_x;
    logic [16383:0]  x_out;

    int total = 0;
    int bad   = 0;
    int lat;
    int npulse;

    deconvolution dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .len_y (len_y),
        .len_k (len_k),
        .y_in  (y_in),
        .h_in  (h_in),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .len_x (len_x),
        .x_out (x_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] xo(input int i);
        return x_out[i*64 +: 64];
    endfunction

    task automatic clr_in();
        y_in = '0;
        h_in = '0;
    endtask

    task automatic sety(input int i, input logic [63:0] v);
        y_in[i*64 +: 64] = v;
    endtask

    task automatic seth(input int i, input logic [63:0] v);
        h_in[i*64 +: 64] = v;
    endtask

    task automatic load_t2();
        clr_in();
        seth(0, F2); seth(1, F1);
        sety(0, F2); sety(1, F5); sety(2, F8); sety(3, F3);
        len_k = 8'd2; len_y = 8'd4;
    endtask

    // Pulse start for one cycle; lat = cycle index (1 = cycle after start edge) of done
    task automatic run(output int l);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        l = -1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (done) begin
                l = c;
                break;
            end
        end
    endtask

    task automatic chk_t2(input string tag);
        chk({tag, "_x0"}, xo(0), F1);
        chk({tag, "_x1"}, xo(1), F2);
        chk({tag, "_x2"}, xo(2), F3);
        chk({tag, "_x3"}, xo(3), 64'd0);
        chk({tag, "_lenx"}, 64'(len_x), 64'd3);
        chk({tag, "_err"}, 64'(err), 64'd0);
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_lenx", 64'(len_x), 64'd0);
        chk("rst_xzero", 64'(x_out === '0), 64'd1);
        reset = 1'b1;

        // T1: Lk=1, h=[2], y=[2,4,6]
        clr_in();
        seth(0, F2);
        sety(0, F2); sety(1, F4); sety(2, F6);
        len_k = 8'd1; len_y = 8'd3;
        run(lat);
        chk("t1_lat", 64'(lat), 64'd8);
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_x0", xo(0), F1);
        chk("t1_x1", xo(1), F2);
        chk("t1_x2", xo(2), F3);
        chk("t1_lenx", 64'(len_x), 64'd3);
        chk("t1_err", 64'(err), 64'd0);
        @(negedge clk);
        chk("t1_done_1cyc", 64'(done), 64'd0);

        // T2: Lk=2, h=[2,1], y=[2,5,8,3]
        load_t2();
        run(lat);
        chk("t2_lat", 64'(lat), 64'd10);
        chk_t2("t2");

        // T3: Lk > Ly
        clr_in();
        seth(0, F2); sety(0, F1);
        len_k = 8'd5; len_y = 8'd3;
        run(lat);
        chk("t3_lat", 64'(lat), 64'd2);
        chk("t3_err", 64'(err), 64'd1);
        chk("t3_lenx", 64'(len_x), 64'd0);
        chk("t3_xzero", 64'(x_out === '0), 64'd1);

        // T4: reset in cycle 5 of a T2 run, then rerun
        load_t2();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        npulse = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (done) npulse++;
        end
        reset = 1'b0;
        @(negedge clk);
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_done", 64'(done), 64'd0);
        chk("t4_xzero", 64'(x_out === '0), 64'd1);
        reset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) npulse++;
        end
        chk("t4_nodone", 64'(npulse), 64'd0);
        run(lat);
        chk("t4_rerun_lat", 64'(lat), 64'd10);
        chk_t2("t4_rerun");

        // T5: h[0] = -0.0, y=[2]
        clr_in();
        seth(0, FNZ); sety(0, F2);
        len_k = 8'd1; len_y = 8'd1;
        run(lat);
`ifdef DECONV_ZERO_CHECK_EN
        chk("t5_lat", 64'(lat), 64'd2);
        chk("t5_err", 64'(err), 64'd1);
        chk("t5_lenx", 64'(len_x), 64'd0);
        chk("t5_xzero", 64'(x_out === '0), 64'd1);
`else
        chk("t5_lat", 64'(lat), 64'd4);
        chk("t5_err", 64'(err), 64'd0);
        chk("t5_x0", xo(0), FNI);
`endif

        // T6: second start while busy is ignored
        load_t2();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        npulse = 0;
        lat = -1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            start = (c == 3);
            if (done) begin
                npulse++;
                if (lat < 0) begin
                    lat = c;
                    chk_t2("t6");
                end
            end
        end
        start = 1'b0;
        chk("t6_pulses", 64'(npulse), 64'd1);
        chk("t6_lat", 64'(lat), 64'd10);

        // T7: negative fractional result, h=[1,0.5], y=[1,0,0]
        clr_in();
        seth(0, F1); seth(1, FH);
        sety(0, F1);
        len_k = 8'd2; len_y = 8'd3;
        run(lat);
        chk("t7_lat", 64'(lat), 64'd7);
        chk("t7_x0", xo(0), F1);
        chk("t7_x1", xo(1), FMH);
        chk("t7_lenx", 64'(len_x), 64'd2);

        // T8: inexact quotient 1/3 rounds to nearest even
        clr_in();
        seth(0, F3); sety(0, F1);
        len_k = 8'd1; len_y = 8'd1;
        run(lat);
        chk("t8_lat", 64'(lat), 64'd4);
        chk("t8_x0", xo(0), F13);
        chk("t8_lenx", 64'(len_x), 64'd1);

        // T9: Lk = 0 is invalid
        clr_in();
        seth(0, F2); sety(0, F2);
        len_k = 8'd0; len_y = 8'd3;
        run(lat);
        chk("t9_lat", 64'(lat), 64'd2);
        chk("t9_err", 64'(err), 64'd1);
        chk("t9_lenx", 64'(len_x), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
